// File: rtl/seg_display_mux.sv
`timescale 1ns/1ps
// Multiplexed NUM_DIGITS hex seven-segment driver with a frame-synchronous double-buffered load.
// Define SEG_DISPLAY_PWM_EN to gate digit enables with a 4-bit PWM brightness counter.
module seg_display_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 5000
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lzb,
  input  logic [3:0]              brightness,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [7:0]              segment
);
  localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int PRE_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);

  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic                    tick;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] active_value;
  logic [4*NUM_DIGITS-1:0] pending_value;
  logic [NUM_DIGITS-1:0]   active_dots;
  logic [NUM_DIGITS-1:0]   pending_dots;
  logic                    pending_full;
  logic                    load_fire;
  logic [3:0]              nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    pwm_on;
  logic [3:0]              cur_nibble;
  logic                    cur_dot;
  logic                    cur_blank;
  logic                    cur_on;
  logic [NUM_DIGITS-1:0]   digit_next;
  logic [7:0]              segment_next;

  assign tick       = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign boundary   = tick && (scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_done = boundary;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pre_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) scan_idx <= boundary ? '0 : scan_idx + 1'b1;
    end
  end

  // A load is only accepted into an empty pending buffer, so promotion and capture never collide.
  assign load_ready = !pending_full;
  assign load_fire  = load_valid && load_ready;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      active_value  <= '0;
      active_dots   <= '0;
      pending_value <= '0;
      pending_dots  <= '0;
      pending_full  <= 1'b0;
    end else begin
      if (boundary && pending_full) begin
        active_value <= pending_value;
        active_dots  <= pending_dots;
      end
      if (load_fire) begin
        pending_value <= value;
        pending_dots  <= dots;
        pending_full  <= 1'b1;
      end else if (boundary) begin
        pending_full <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = active_value[4*gi +: 4];
      assign sel[gi]    = (scan_idx == IDX_W'(gi));
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = lzb && (active_value[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

`ifdef SEG_DISPLAY_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt <= brightness);
`else
  logic brightness_unused;
  assign brightness_unused = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  // A blank digit with its dot set stays enabled so the point remains visible.
  always_comb begin
    cur_nibble   = nibble[scan_idx];
    cur_dot      = active_dots[scan_idx];
    cur_blank    = blank[scan_idx];
    segment_next = {(cur_blank ? 7'h7F : decode(cur_nibble)), ~cur_dot};
    cur_on       = (!cur_blank || cur_dot) && pwm_on;
    digit_next   = cur_on ? ~sel : '1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      digit   <= '1;
      segment <= '1;
    end else begin
      digit   <= digit_next;
      segment <= segment_next;
    end
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Parametrised multiplexed seven-segment display driver. Successor to the fixed 4-digit display interface.
- Scans NUM_DIGITS hex digits with a programmable refresh rate.
- Double-buffers the display value behind a valid/ready load handshake, so digits only update at frame boundaries.
- Adds optional leading-zero blanking and PWM brightness. Sits between the value source and the board digit/segment pins; clocked at 5 MHz.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- TICK_DIV, 5000, clocks per digit slot (>=2); 5000 gives 1 kHz digit rate at 5 MHz.

Ports:
- clock  input  1  system clock (5 MHz).
- rstn  input  1  asynchronous active-low reset.
- value  input  4*NUM_DIGITS  hex value; nibble i drives digit i (digit 0 rightmost).
- dots  input  NUM_DIGITS  decimal point enables, bit i for digit i, active high.
- load_valid  input  1  value/dots offered for loading.
- load_ready  output  1  pending buffer free.
- lzb  input  1  leading-zero blanking enable (static level).
- brightness  input  4  PWM duty code.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- digit  output  NUM_DIGITS  digit enables, active low.
- segment  output  8  segments {a,b,c,d,e,f,g,p}, active low, a = bit 7.

Behaviour:
- Reset (async, rstn=0): prescaler=0, scan index=0, active value/dots=0, pending empty, load_ready=1, frame_done=0, digit=all 1s, segment=all 1s.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick asserts when count==TICK_DIV-1.
- Scan index: advances on tick, wrapping from NUM_DIGITS-1 to 0. Width is $clog2(NUM_DIGITS), minimum 1.
- Frame boundary: tick while scan index==NUM_DIGITS-1. frame_done pulses high in that same cycle.
- Load handshake: a transfer occurs when load_valid & load_ready. It captures value and dots into the pending buffer, marks it full, and drops load_ready on the next cycle.
- At a frame boundary with pending full: pending moves to active, pending clears, load_ready=1 on the next cycle.
- A load and a frame boundary in the same cycle: the existing pending data (if any) moves to active. A load in that cycle is only possible if pending was empty; the new data is stored as pending and waits for the next boundary.
- Active data never changes mid-frame.
- Output registers: digit and segment are registered and lag the scan index by exactly 1 clock. Only the selected digit bit is 0; all others are 1.
- Decode (abcdefg, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - p = ~dots[i].
- Blanking, with lzb=1:
  - Digit i>0 is blank if nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blank.
  - Blank digit: a..g=1. If its dot is set, p is still driven 0 and the digit enable stays active. If its dot is clear, the digit enable is also held 1.
  - lzb is sampled every cycle against the active value.
- No combinational path from any input to digit or segment.

Optional Feature:
- Macro: SEG_DISPLAY_PWM_EN.
- When defined:
  - A 4-bit free-running PWM counter increments every clock and is reset to 0.
  - A selected digit's enable is driven low only when pwm_cnt <= brightness; otherwise it is 1. Duty is (brightness+1)/16; 15 means always on.
  - segment is unaffected.
- When undefined:
  - The brightness port is present but ignored.
  - The selected digit is always enabled (equivalent to brightness=15).
  - No PWM counter is synthesised.

Test Plan:
- Reset: hold rstn=0 mid-scan with random inputs -> digit=FF, segment=FF, load_ready=1 immediately. Release -> first digit change after TICK_DIV+1 clocks.
- Scan order (NUM_DIGITS=4, TICK_DIV=4):
  - After reset, digit sequence 1110,1101,1011,0111,1110 with each held 4 clocks.
  - frame_done pulses every 16 clocks.
- Handshake:
  - Load 0x1234 mid-frame -> load_ready=0 next cycle; display keeps 0x0000 until the frame boundary, then shows 4,3,2,1 on digits 0..3; load_ready returns 1.
  - A second load_valid while not ready -> ignored.
- Decode/dots: load 0xAbCd pattern 0xA5F0, dots=0101 -> digit0 segment=00000010, digit1 segment=01110001, digit2 segment=01001000, digit3 segment=00010001.
- Blanking: lzb=1, value 0x0050, dots=0000 -> digit0 shows 0, digit1 shows 5, digits 2-3 enable stays 1. Dots=1000 -> digit3 enabled with segment=11111110.
- PWM (macro on): brightness=3 -> selected digit enabled exactly 4 of every 16 clocks. brightness=15 -> continuously enabled. Macro off with brightness=3 -> continuously enabled.
